life_generation_engine: RTL and testbench
=========================================

// Module: life_generation_engine
// PURPOSE
//  Conway Game of Life core: holds the live 8x8 cell grid, computes successive generations on a
//  toroidal board, and serves rows to the downstream LED matrix scanner. The scanner drives rd_row
//  from its 3-bit row counter and places rd_data directly onto column_driver.
//  The grid is double-buffered, so the displayed frame never tears while a generation is being computed.
// PARAMETERS
//  N        8             grid rows = columns. Fixed at 8 for this board; the package constant mirrors it.
//  GEN_DIV  50_000_000    sysclk cycles per auto-run generation tick (1 Hz at 50 MHz).
//  SEED     glider        N*N-bit reset pattern, row 0 first, MSB = column 0.
//                         Default rows 0..7: 00100000,00010000,01110000,00000000 x5.
// PORTS
//  sysclk     in   1   system clock, 50 MHz
//  reset_n    in   1   asynchronous active-low reset
//  run        in   1   level; 1 = advance one generation every GEN_DIV cycles
//  step       in   1   single-cycle pulse; request one generation
//  load_en    in   1   write load_data into row load_row of the current grid
//  load_row   in   3   row index for load
//  load_data  in   8   row pattern; bit 7 = column 0
//  rd_row     in   3   scanner row select
//  rd_data    out  8   current-grid row rd_row; bit 7 = column 0; combinational read
//  busy       out  1   1 while in COMPUTE or SWAP
//  gen_count  out  16  generations completed since reset
// BEHAVIOUR
//  - Reset (async, released synchronously to sysclk):
//    cur grid = SEED, nxt grid = 0, state = IDLE, busy = 0, gen_count = 0, tick divider = 0.
//  - Cell rule: n = live count of the 8 neighbours, with indices mod N (toroidal).
//    next = (n==3) | (alive & n==2). n is 4 bits wide and never exceeds 8.
//  - FSM IDLE -> COMPUTE -> SWAP -> IDLE.
//    IDLE: a request (step=1, or an auto tick while run=1) moves to COMPUTE with row counter r = 0.
//    COMPUTE: each cycle writes nxt[r] = rule(cur[r-1], cur[r], cur[r+1]), r++.
//      After r = N-1 the FSM moves to SWAP.
//    SWAP: one cycle; cur <= nxt, gen_count++ (wraps 0xFFFF -> 0).
//  - Latency: request accepted on edge k; busy = 1 from k+1; the new grid is visible on rd_data from k+N+2.
//    Total is N+1 = 9 busy cycles.
//  - Tick divider: counts 0..GEN_DIV-1 only while run=1 and holds at 0 when run=0.
//    A tick or step arriving while busy is dropped and never queued. step and tick in the same cycle count as one request.
//  - load_en: honoured only in IDLE; ignored while busy.
//    load_en and a request in the same IDLE cycle: the load is applied and the request is dropped.
//  - rd_data always reflects cur. It is unaffected by COMPUTE and changes only at the SWAP edge or on a load.
//  - reset_n asserted mid-COMPUTE: partial nxt is discarded, all state returns to reset values immediately, and no SWAP occurs.
// STRUCTURE
//  - Package conway_pkg: localparam N = 8; typedef logic [N-1:0] row_t; typedef row_t [0:N-1] grid_t;
//    typedef enum logic [1:0] {IDLE, COMPUTE, SWAP} life_state_t; function wrap_idx(int i).
//  - Sub-module life_row_next: combinational; inputs above, row, below (row_t); output next row_t.
//    It contains N cell evaluators with column wrap. The engine instantiates it once and time-multiplexes it over rows.
// TESTING
//  1. Reset with default SEED, rd_row 0..2 -> rd_data = 20h, 10h, 70h. Remaining rows = 00h; busy = 0; gen_count = 0.
//  2. Blinker: load row3 = 38h and other rows 00h, then one step -> busy high for exactly 9 cycles.
//     After completion rows 2, 3, 4 = 10h, others 00h, gen_count = 1. A second step restores row 3 = 38h.
//  3. Glider wrap: default SEED, 32 steps -> grid identical to SEED, gen_count = 32.
//     After 4 steps the glider is shifted +1 row and +1 column (rows 1..3 = 10h, 08h, 38h).
//  4. Still life and edge wrap: block at rows 0 and 7 with cols 0 and 7 (rows 0, 7 = 81h) -> unchanged after 5 steps.
//  5. Hazards: step while busy is dropped (gen_count +1 only); load_en while busy leaves cur unchanged;
//     load_en + step in IDLE loads and busy stays 0. rd_data is stable during COMPUTE.
//  6. run = 1 with GEN_DIV = 20 -> exactly one generation per 20 cycles.
//     reset_n pulsed mid-COMPUTE -> grid = SEED and gen_count = 0 the same cycle; no SWAP follows.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types and constants for the 8x8 toroidal Game of Life engine.
package conway_pkg;

  localparam int N = 8;

  typedef logic [N-1:0] row_t;
  typedef row_t [0:N-1] grid_t;

  typedef enum logic [1:0] {IDLE, COMPUTE, SWAP} life_state_t;

  function automatic int wrap_idx(int i);
    return ((i % N) + N) % N;
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation evaluator for one row, given its vertical neighbours.
// Column 0 is the MSB; columns wrap around the board edges.
module life_row_next
  import conway_pkg::*;
(
  input  row_t above,
  input  row_t row,
  input  row_t below,
  output row_t next
);

  for (genvar c = 0; c < N; c++) begin : g_cell
    // Bit positions of this column and its wrapped left/right neighbours.
    localparam int CB = N - 1 - c;
    localparam int LB = N - 1 - wrap_idx(c - 1);
    localparam int RB = N - 1 - wrap_idx(c + 1);

    logic [3:0] w_n;

    assign w_n = 4'(above[LB]) + 4'(above[CB]) + 4'(above[RB])
               + 4'(row[LB])                    + 4'(row[RB])
               + 4'(below[LB]) + 4'(below[CB]) + 4'(below[RB]);

    assign next[CB] = (w_n == 4'd3) | (row[CB] & (w_n == 4'd2));
  end

endmodule

// File: rtl/life_generation_engine.sv
// Game of Life core: double-buffered 8x8 grid, one row evaluated per cycle,
// current grid served combinationally to the LED scanner.
module life_generation_engine
  import conway_pkg::*;
#(
  parameter int               GEN_DIV = 50_000_000,
  parameter logic [N*N-1:0]   SEED    = 64'h2010_7000_0000_0000
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        step,
  input  logic        load_en,
  input  logic [2:0]  load_row,
  input  logic [7:0]  load_data,
  input  logic [2:0]  rd_row,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic [15:0] gen_count,
  output life_state_t state_dbg
);

  localparam int DW = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;

  function automatic grid_t seed_grid();
    grid_t g;
    for (int r = 0; r < N; r++) g[r] = SEED[N*N-1-r*N -: N];
    return g;
  endfunction

  life_state_t r_state, w_state_nxt;
  grid_t       r_cur, r_nxt;
  logic [2:0]  r_row;
  logic [DW-1:0] r_div;
  logic [15:0] r_gen;

  logic        w_tick, w_accept;
  logic [2:0]  w_up_idx, w_dn_idx;
  row_t        w_next_row;

  // Request handshake: step or an auto tick is taken only in IDLE with load_en low;
  // anything arriving otherwise is dropped, never queued.
  assign w_tick   = run && (r_div == DW'(GEN_DIV - 1));
  assign w_accept = (r_state == IDLE) && (step || w_tick) && !load_en;

  assign w_up_idx = 3'(wrap_idx(int'(r_row) - 1));
  assign w_dn_idx = 3'(wrap_idx(int'(r_row) + 1));

  life_row_next u_row_next (
    .above (r_cur[w_up_idx]),
    .row   (r_cur[r_row]),
    .below (r_cur[w_dn_idx]),
    .next  (w_next_row)
  );

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = COMPUTE;
      COMPUTE: if (r_row == 3'(N - 1)) w_state_nxt = SWAP;
      SWAP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n)                  r_div <= '0;
    else if (!run || w_tick)       r_div <= '0;
    else                           r_div <= r_div + 1'b1;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur <= seed_grid();
      r_nxt <= '0;
      r_row <= '0;
      r_gen <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_row <= '0;
          if (load_en) r_cur[load_row] <= load_data;
        end
        COMPUTE: begin
          r_nxt[r_row] <= w_next_row;
          r_row        <= r_row + 3'd1;
        end
        SWAP: begin
          r_cur <= r_nxt;
          r_gen <= r_gen + 16'd1;
        end
        default: r_row <= '0;
      endcase
    end
  end

  assign rd_data   = r_cur[rd_row];
  assign busy      = (r_state != IDLE);
  assign gen_count = r_gen;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_life_generation_engine.sv
// Directed-vector bench for life_generation_engine with hand-computed grids.
module tb_life_generation_engine;
  import conway_pkg::*;

  localparam logic [63:0] GLIDER   = 64'h2010_7000_0000_0000;
  localparam logic [63:0] BLINK_H  = 64'h0000_0038_0000_0000;
  localparam logic [63:0] BLINK_V  = 64'h0000_1010_1000_0000;
  localparam logic [63:0] GLIDER4  = 64'h0010_0838_0000_0000;
  localparam logic [63:0] CORNERS  = 64'h8100_0000_0000_0081;

  logic        sysclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        load_en = 1'b0;
  logic [2:0]  load_row = '0;
  logic [7:0]  load_data = '0;
  logic [2:0]  rd_row = '0;
  logic [7:0]  rd_data;
  logic        busy;
  logic [15:0] gen_count;
  life_state_t state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_gen  = 0;

  always #5 sysclk = ~sysclk;

  life_generation_engine #(.GEN_DIV(20)) dut (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .run       (run),
    .step      (step),
    .load_en   (load_en),
    .load_row  (load_row),
    .load_data (load_data),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .busy      (busy),
    .gen_count (gen_count),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %04h expected %04h", tag, obs, exp);
  endtask

  task automatic apply_reset();
    @(negedge sysclk);
    reset_n = 1'b0; run = 1'b0; step = 1'b0; load_en = 1'b0;
    repeat (2) @(negedge sysclk);
    reset_n = 1'b1;
    @(negedge sysclk);
    exp_gen = 0;
  endtask

  task automatic check_grid(input string tag, input logic [63:0] g);
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      #1;
      check($sformatf("%s_row%0d", tag, r), 16'(rd_data), 16'(g[63-8*r -: 8]));
    end
  endtask

  task automatic load_grid(input logic [63:0] g);
    for (int r = 0; r < 8; r++) begin
      @(negedge sysclk);
      load_en = 1'b1; load_row = 3'(r); load_data = g[63-8*r -: 8];
    end
    @(negedge sysclk);
    load_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge sysclk);
    end
    check({tag, "_idle_timeout"}, 16'(n < 50), 16'd1);
  endtask

  task automatic do_step(output int busy_cycles);
    @(negedge sysclk); step = 1'b1;
    @(negedge sysclk); step = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 50) begin
      busy_cycles++;
      @(negedge sysclk);
    end
  endtask

  task automatic do_steps(input string tag, input int k);
    int bc, bad;
    bad = 0;
    for (int i = 0; i < k; i++) begin
      do_step(bc);
      if (bc != 9) bad++;
      exp_gen++;
    end
    check({tag, "_busy_len"}, 16'(bad), 16'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, last, bad;
    logic [15:0] prev;

    // Reset state
    apply_reset();
    check_grid("t1_seed", GLIDER);
    check("t1_busy", 16'(busy), 16'd0);
    check("t1_gen", gen_count, 16'd0);
    check("t1_state", 16'(state_dbg), 16'(IDLE));

    // Blinker oscillation and busy duration
    load_grid(BLINK_H);
    check_grid("t2_loaded", BLINK_H);
    do_step(bc);
    exp_gen++;
    check("t2_busy_cycles", 16'(bc), 16'd9);
    check_grid("t2_vert", BLINK_V);
    check("t2_gen1", gen_count, 16'(exp_gen));
    do_steps("t2_back", 1);
    check_grid("t2_horiz", BLINK_H);

    // Glider travels around the torus
    apply_reset();
    do_steps("t3_first4", 4);
    check_grid("t3_shift", GLIDER4);
    do_steps("t3_rest", 28);
    check_grid("t3_wrap", GLIDER);
    check("t3_gen32", gen_count, 16'd32);

    // Block straddling all four corners is a still life
    load_grid(CORNERS);
    do_steps("t4", 5);
    check_grid("t4_block", CORNERS);
    check("t4_gen", gen_count, 16'(exp_gen));

    // Hazards: step and load while busy, load+step in IDLE
    load_grid(BLINK_H);
    @(negedge sysclk); step = 1'b1;
    @(negedge sysclk); step = 1'b0;
    rd_row = 3'd3; #1;
    check("t5_busy", 16'(busy), 16'd1);
    check("t5_rd_compute0", 16'(rd_data), 16'h0038);
    @(negedge sysclk);
    step = 1'b1; load_en = 1'b1; load_row = 3'd3; load_data = 8'hFF;
    @(negedge sysclk);
    step = 1'b0; load_en = 1'b0;
    rd_row = 3'd3; #1;
    check("t5_rd_compute1", 16'(rd_data), 16'h0038);
    wait_idle("t5");
    exp_gen++;
    check("t5_gen_once", gen_count, 16'(exp_gen));
    repeat (3) @(negedge sysclk);
    check("t5_no_queued", 16'(busy), 16'd0);
    check_grid("t5_vert", BLINK_V);
    @(negedge sysclk);
    load_en = 1'b1; load_row = 3'd5; load_data = 8'h42; step = 1'b1;
    @(negedge sysclk);
    load_en = 1'b0; step = 1'b0;
    rd_row = 3'd5; #1;
    check("t5_ld_step_busy", 16'(busy), 16'd0);
    check("t5_ld_step_row5", 16'(rd_data), 16'h0042);
    @(negedge sysclk);
    check("t5_ld_step_busy2", 16'(busy), 16'd0);
    check("t5_ld_step_gen", gen_count, 16'(exp_gen));

    // Auto-run: one generation every 20 cycles
    apply_reset();
    @(negedge sysclk); run = 1'b1;
    last = -1; bad = 0; prev = 16'd0;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      @(negedge sysclk);
      if (gen_count != prev) begin
        if (last >= 0 && (cyc - last) != 20) bad++;
        last = cyc;
        prev = gen_count;
      end
    end
    run = 1'b0;
    wait_idle("t6_run");
    check("t6_run_gen", gen_count, 16'd5);
    check("t6_run_interval", 16'(bad), 16'd0);

    // Reset mid-COMPUTE
    @(negedge sysclk); step = 1'b1;
    @(negedge sysclk); step = 1'b0;
    repeat (2) @(negedge sysclk);
    check("t6_pre_busy", 16'(busy), 16'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_gen", gen_count, 16'd0);
    check("t6_rst_busy", 16'(busy), 16'd0);
    check_grid("t6_rst_grid", GLIDER);
    @(negedge sysclk);
    reset_n = 1'b1;
    repeat (15) @(negedge sysclk);
    check("t6_post_gen", gen_count, 16'd0);
    check("t6_post_busy", 16'(busy), 16'd0);
    check_grid("t6_post_grid", GLIDER);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
